// File: rtl/pipemem_ctrl_pkg.sv
// ============================================================================
// Module      : pipemem_ctrl_pkg
// Description : Shared definitions for the MEM-stage controller: FSM state
//               encoding, MEM/WB bubble constant, alignment mask and helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipemem_ctrl_pkg;

    // Controller state: waiting for a memory op, or holding an outstanding access.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Control bits {wwreg, wm2reg} written into MEM/WB when no instruction retires.
    localparam logic [1:0] C_BUBBLE_CTRL = 2'b00;

    // Byte-offset bits that must be zero for a word access.
    localparam logic [1:0] C_ALIGN_MASK = 2'b11;

    // True when the low address bits describe a word-aligned access.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & C_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipemem_ctrl_wait_cnt.sv
// ============================================================================
// Module      : pipe_wait_cnt
// Description : Saturating wait counter for an outstanding memory access.
//               Cleared when an access is launched, incremented for every
//               BUSY cycle without an acknowledge; expire flags that MAX_WAIT
//               full wait cycles have already elapsed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_wait_cnt #(
    parameter int MAX_WAIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            W       = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0]  C_LIMIT = W'(MAX_WAIT);
    localparam logic [W-1:0]  C_ONE   = W'(1);

    logic [W-1:0] r_count;

    // Count wait cycles; clear has priority, the count never wraps past the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != C_LIMIT)) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign expire = (r_count == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/pipemem_ctrl.sv
// ============================================================================
// Module      : pipemem_ctrl
// Description : MEM-stage controller. Launches loads/stores seen at the output
//               of the EXE/MEM register over a req/ack memory port, stalls the
//               upstream pipeline while an access is outstanding, aborts an
//               access after MAX_WAIT unacknowledged wait cycles, flags
//               misaligned addresses, and holds the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipemem_ctrl
    import pipemem_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    // MEM-stage instruction (EXE/MEM register outputs)
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [DATA_W-1:0] malu,
    input  logic [DATA_W-1:0] mb,
    input  logic [4:0]        mrn,
    // Data-memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    // Pipeline control
    output logic              mem_stall,
    output logic              mem_err,
    // MEM/WB register
    output logic              wwreg,
    output logic              wm2reg,
    output logic [DATA_W-1:0] wmo,
    output logic [DATA_W-1:0] walu,
    output logic [4:0]        wrn
);

    state_t r_state;
    state_t w_state_next;

    logic w_op;
    logic w_aligned;
    logic w_accept;
    logic w_misalign;
    logic w_done;
    logic w_timeout;
    logic w_pass;
    logic w_stall;
    logic w_cnt_en;
    logic w_expire;

    assign w_op      = mm2reg | mwmem;
    assign w_aligned = is_word_aligned(malu[1:0]);

    // Wait-cycle counter for the outstanding access.
    pipe_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clock  (clock),
        .reset  (reset),
        .clr    (w_accept),
        .en     (w_cnt_en),
        .expire (w_expire)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle decisions; an ack beats a simultaneous timeout.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_misalign   = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        w_pass       = 1'b0;
        w_stall      = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_op) begin
                    w_pass = 1'b1;
                end else if (!w_aligned) begin
                    w_misalign = 1'b1;
                end else begin
                    w_accept     = 1'b1;
                    w_stall      = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else if (w_expire) begin
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_stall  = 1'b1;
                    w_cnt_en = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // The upstream pipeline is never frozen while the controller is held in reset.
    assign mem_stall = w_stall & ~reset;

    // Request capture: fields are latched on launch and held until ack or abort.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (w_accept) begin
            mem_req   <= 1'b1;
            mem_we    <= mwmem;
            mem_addr  <= malu;
            mem_wdata <= mb;
        end else if (w_done || w_timeout) begin
            mem_req   <= 1'b0;
        end
    end

    // Error pulse for a misaligned address or an aborted access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= w_misalign | w_timeout;
        end
    end

    // MEM/WB register: retire pass-through or acknowledged ops, otherwise a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wmo    <= '0;
            walu   <= '0;
            wrn    <= '0;
        end else if (w_pass) begin
            wwreg  <= mwreg;
            wm2reg <= 1'b0;
            walu   <= malu;
            wrn    <= mrn;
        end else if (w_done) begin
            wwreg  <= mwreg;
            wm2reg <= mm2reg;
            walu   <= malu;
            wrn    <= mrn;
            if (mm2reg) begin
                wmo <= mem_rdata;
            end
        end else begin
            {wwreg, wm2reg} <= C_BUBBLE_CTRL;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipemem_ctrl.sv
// ============================================================================
// Module      : tb_pipemem_ctrl
// Description : Self-checking bench for pipemem_ctrl: directed scenarios
//               followed by randomized instructions against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipemem_ctrl;

    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 15;

    logic              clock;
    logic              reset;
    logic              mwreg, mm2reg, mwmem;
    logic [DATA_W-1:0] malu, mb;
    logic [4:0]        mrn;
    logic              mem_req, mem_we;
    logic [DATA_W-1:0] mem_addr, mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stall, mem_err;
    logic              wwreg, wm2reg;
    logic [DATA_W-1:0] wmo, walu;
    logic [4:0]        wrn;

    int checks   = 0;
    int failures = 0;

    // Reference model of the MEM/WB register contents.
    logic              exp_wwreg, exp_wm2reg;
    logic [DATA_W-1:0] exp_wmo, exp_walu;
    logic [4:0]        exp_wrn;

    pipemem_ctrl #(
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .malu      (malu),
        .mb        (mb),
        .mrn       (mrn),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall),
        .mem_err   (mem_err),
        .wwreg     (wwreg),
        .wm2reg    (wm2reg),
        .wmo       (wmo),
        .walu      (walu),
        .wrn       (wrn)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag);
        chk({tag, "_wwreg"},  wwreg,  exp_wwreg);
        chk({tag, "_wm2reg"}, wm2reg, exp_wm2reg);
        chk({tag, "_wmo"},    wmo,    exp_wmo);
        chk({tag, "_walu"},   walu,   exp_walu);
        chk({tag, "_wrn"},    wrn,    exp_wrn);
    endtask

    // One instruction presented to the MEM stage. Starts and ends on a negedge.
    // ack_at: index of the waiting cycle that carries mem_ack (-1 = never).
    task automatic run_instr(input logic wreg, input logic m2reg, input logic wmem,
                             input logic [31:0] alu, input logic [31:0] b,
                             input logic [4:0] rn, input int ack_at,
                             input logic [31:0] rdata);
        logic is_mem;
        logic misal;
        int   stalls;
        is_mem    = m2reg | wmem;
        misal     = is_mem && ((alu % 4) != 0);
        mwreg     = wreg;
        mm2reg    = m2reg;
        mwmem     = wmem;
        malu      = alu;
        mb        = b;
        mrn       = rn;
        mem_rdata = $urandom;
        mem_ack   = is_mem ? 1'b0 : 1'($urandom_range(0, 1));
        #1;
        if (!is_mem || misal) begin
            chk("nostall", mem_stall, 1'b0);
            @(posedge clock); #1;
            chk("noreq", mem_req, 1'b0);
            if (misal) begin
                exp_wwreg  = 1'b0;
                exp_wm2reg = 1'b0;
                chk("misal_err",    mem_err, 1'b1);
                chk("misal_wwreg",  wwreg,   1'b0);
                chk("misal_wm2reg", wm2reg,  1'b0);
            end else begin
                exp_wwreg  = wreg;
                exp_wm2reg = 1'b0;
                exp_walu   = alu;
                exp_wrn    = rn;
                chk("pass_err", mem_err, 1'b0);
                chk_wb("pass");
            end
            @(negedge clock);
        end else begin
            stalls = 0;
            chk("accept_stall", mem_stall, 1'b1);
            if (mem_stall === 1'b1) stalls++;
            @(posedge clock); #1;
            chk("req_set",   mem_req,   1'b1);
            chk("req_we",    mem_we,    wmem);
            chk("req_addr",  mem_addr,  alu);
            chk("req_wdata", mem_wdata, b);
            chk("accept_bubble", wwreg, 1'b0);
            @(negedge clock);
            for (int cyc = 0; cyc <= MAX_WAIT; cyc++) begin
                mem_ack   = (cyc == ack_at);
                mem_rdata = (cyc == ack_at) ? rdata : $urandom;
                #1;
                chk("busy_stall", mem_stall, (cyc != ack_at) && (cyc < MAX_WAIT));
                if (mem_stall === 1'b1) stalls++;
                chk("busy_req",  mem_req,  1'b1);
                chk("busy_addr", mem_addr, alu);
                @(posedge clock); #1;
                if (cyc == ack_at) begin
                    exp_wwreg  = wreg;
                    exp_wm2reg = m2reg;
                    exp_walu   = alu;
                    exp_wrn    = rn;
                    if (m2reg) exp_wmo = rdata;
                    chk("ack_req", mem_req, 1'b0);
                    chk("ack_err", mem_err, 1'b0);
                    chk_wb("ack");
                    break;
                end else if (cyc == MAX_WAIT) begin
                    exp_wwreg  = 1'b0;
                    exp_wm2reg = 1'b0;
                    chk("tmo_err",    mem_err, 1'b1);
                    chk("tmo_req",    mem_req, 1'b0);
                    chk("tmo_wwreg",  wwreg,   1'b0);
                    chk("tmo_wm2reg", wm2reg,  1'b0);
                    break;
                end else begin
                    chk("wait_bubble", wwreg, 1'b0);
                end
                @(negedge clock);
            end
            chk("stall_cycles", stalls, (ack_at >= 0) ? ack_at + 1 : MAX_WAIT + 1);
            @(negedge clock);
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        int          kind;
        int          ack_at;
        logic [31:0] a;
        logic [4:0]  rn;

        // Reset state
        reset = 1'b1;
        mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
        malu = '0; mb = '0; mrn = '0; mem_ack = 1'b0; mem_rdata = '0;
        exp_wwreg = 1'b0; exp_wm2reg = 1'b0; exp_wmo = '0; exp_walu = '0; exp_wrn = '0;
        #1;
        chk("rst_req",   mem_req,   1'b0);
        chk("rst_we",    mem_we,    1'b0);
        chk("rst_addr",  mem_addr,  '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_err",   mem_err,   1'b0);
        chk_wb("rst");
        @(negedge clock);
        reset = 1'b0;

        // Pass-through
        run_instr(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, -1, 32'h0);
        // Load acknowledged after three wait cycles
        run_instr(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd9, 3, 32'hDEADBEEF);
        // Store with immediate ack
        run_instr(1'b0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 5'd0, 0, 32'h0);
        // Misaligned load, then a pass-through that sees the error drop
        run_instr(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd3, -1, 32'h0);
        run_instr(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd6, -1, 32'h0);
        // Timeout, then ack in the final allowed cycle
        run_instr(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd4, -1, 32'h0);
        run_instr(1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 5'd4, MAX_WAIT, 32'h55AA1234);
        // Back-to-back memory ops
        run_instr(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd10, 0, 32'h01020304);
        run_instr(1'b0, 1'b0, 1'b1, 32'h304, 32'hCAFEF00D, 5'd0, 0, 32'h0);
        run_instr(1'b1, 1'b1, 1'b0, 32'h308, 32'h0, 5'd11, 1, 32'h0BADC0DE);

        // Asynchronous reset in the middle of an outstanding load
        mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h40; mrn = 5'd7; mem_ack = 1'b0;
        @(posedge clock); #1;
        chk("pre_rst_req", mem_req, 1'b1);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        exp_wwreg = 1'b0; exp_wm2reg = 1'b0; exp_wmo = '0; exp_walu = '0; exp_wrn = '0;
        chk("midrst_req",   mem_req,   1'b0);
        chk("midrst_stall", mem_stall, 1'b0);
        chk("midrst_err",   mem_err,   1'b0);
        chk_wb("midrst");
        @(negedge clock);
        reset = 1'b0;
        run_instr(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd12, 2, 32'h13572468);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom & 32'hFFFF_FFFC;
            rn   = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 9))
                0:       ack_at = -1;
                1:       ack_at = MAX_WAIT;
                default: ack_at = $urandom_range(0, 4);
            endcase
            case (kind)
                0: run_instr(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom, $urandom, rn, -1, 32'h0);
                1: run_instr(1'b1, 1'b1, 1'b0, a, $urandom, rn, ack_at, $urandom);
                2: run_instr(1'b0, 1'b0, 1'b1, a, $urandom, rn, ack_at, $urandom);
                default: run_instr(1'b1, 1'($urandom_range(0, 1)), 1'b1,
                                   a | 32'($urandom_range(1, 3)), $urandom, rn, -1, 32'h0);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
